// File: rtl/rst_sequencer_if.sv
// Request/response bundle between the reset-request source and rst_sequencer.
// master: the side issuing requests and observing the reset outputs.
// slave:  the sequencer itself.
interface rst_sequencer_if;
  logic sys_rst_req;
  logic boot_rst_req;
  logic rst_core;
  logic rst_periph;
  logic boot_programn;
  logic led_warn;
  logic busy;

  modport master (
    output sys_rst_req,
    output boot_rst_req,
    input  rst_core,
    input  rst_periph,
    input  boot_programn,
    input  led_warn,
    input  busy
  );

  modport slave (
    input  sys_rst_req,
    input  boot_rst_req,
    output rst_core,
    output rst_periph,
    output boot_programn,
    output led_warn,
    output busy
  );
endinterface

// File: rtl/rst_sequencer.sv
// rst_sequencer: turns sys/boot reset request pulses into an ordered reset
// release (core first, peripherals after a gap) or a boot warning blink
// followed by a held PROGRAMN drive.
// Optional feature: define RST_SEQ_BOOT_ABORT_EN to let a sys request edge
// abort a boot that is still in its warning period.
module rst_sequencer #(
  parameter int unsigned CLK_FREQUENCY        = 48000000,
  parameter int unsigned REQ_LOGIC_LEVEL      = 1,
  parameter int unsigned RST_HOLD_CYCLES      = 1024,
  parameter int unsigned STAGE_GAP_CYCLES     = 256,
  parameter int unsigned BOOT_WARN_MS         = 500,
  parameter int unsigned BLINK_HZ             = 8,
  parameter int unsigned PROGRAMN_LOGIC_LEVEL = 0
) (
  input  logic           clk,
  input  logic           rst,
  rst_sequencer_if.slave bus
);

  // 64-bit arithmetic: CLK_FREQUENCY * BOOT_WARN_MS overflows 32 bits at 48 MHz.
  localparam longint unsigned BOOT_WARN_CYCLES =
    (64'(CLK_FREQUENCY) * 64'(BOOT_WARN_MS)) / 64'd1000;
  localparam longint unsigned MAX_HG =
    (RST_HOLD_CYCLES > STAGE_GAP_CYCLES) ? 64'(RST_HOLD_CYCLES) : 64'(STAGE_GAP_CYCLES);
  localparam longint unsigned CNT_MAX =
    (MAX_HG > BOOT_WARN_CYCLES) ? MAX_HG : BOOT_WARN_CYCLES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 64'd1);

  localparam longint unsigned HALF_PERIOD =
    64'(CLK_FREQUENCY) / (64'd2 * 64'(BLINK_HZ));
  localparam int unsigned BLINK_W = (HALF_PERIOD > 64'd1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(64'(RST_HOLD_CYCLES) - 64'd1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(64'(STAGE_GAP_CYCLES) - 64'd1);
  localparam logic [CNT_W-1:0]   WARN_LAST  = CNT_W'(BOOT_WARN_CYCLES - 64'd1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF_PERIOD - 64'd1);

  localparam logic REQ_ACT  = 1'(REQ_LOGIC_LEVEL);
  localparam logic PROG_ACT = 1'(PROGRAMN_LOGIC_LEVEL);

`ifdef RST_SEQ_BOOT_ABORT_EN
  localparam logic ABORT_EN = 1'b1;
`else
  localparam logic ABORT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_REL_CORE  = 3'd1,
    S_RUN       = 3'd2,
    S_BOOT_WARN = 3'd3,
    S_BOOT_FIRE = 3'd4
  } state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BLINK_W-1:0] r_blink;
  logic               r_rst_core;
  logic               r_rst_periph;
  logic               r_programn;
  logic               r_led_warn;
  logic               r_busy;

  logic r_sys_s;
  logic r_sys_h;
  logic r_boot_s;
  logic r_boot_h;

  logic w_sys_act;
  logic w_boot_act;
  logic w_sys_edge;
  logic w_boot_edge;

  assign w_sys_act  = (bus.sys_rst_req  == REQ_ACT);
  assign w_boot_act = (bus.boot_rst_req == REQ_ACT);

  // Request sampling; during rst the history follows the live level so a
  // request held through rst is never treated as new.
  always_ff @(posedge clk) begin
    r_sys_s  <= w_sys_act;
    r_boot_s <= w_boot_act;
    if (rst) begin
      r_sys_h  <= w_sys_act;
      r_boot_h <= w_boot_act;
    end else begin
      r_sys_h  <= r_sys_s;
      r_boot_h <= r_boot_s;
    end
  end

  assign w_sys_edge  = r_sys_s  & ~r_sys_h;
  assign w_boot_edge = r_boot_s & ~r_boot_h;

  // Sequencer FSM with registered outputs; counters cleared on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_HOLD;
      r_cnt        <= '0;
      r_blink      <= '0;
      r_rst_core   <= 1'b1;
      r_rst_periph <= 1'b1;
      r_programn   <= ~PROG_ACT;
      r_led_warn   <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      case (r_state)
        S_HOLD, S_REL_CORE, S_RUN: begin
          if (w_boot_edge) begin
            r_state      <= S_BOOT_WARN;
            r_cnt        <= '0;
            r_blink      <= '0;
            r_rst_core   <= 1'b1;
            r_rst_periph <= 1'b1;
            r_led_warn   <= 1'b1;
            r_busy       <= 1'b1;
          end else if (w_sys_edge) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_rst_core   <= 1'b1;
            r_rst_periph <= 1'b1;
            r_busy       <= 1'b1;
          end else if (r_state == S_HOLD) begin
            if (r_cnt == HOLD_LAST) begin
              r_state    <= S_REL_CORE;
              r_cnt      <= '0;
              r_rst_core <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (r_state == S_REL_CORE) begin
            if (r_cnt == GAP_LAST) begin
              r_state      <= S_RUN;
              r_cnt        <= '0;
              r_rst_periph <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        S_BOOT_WARN: begin
          if (ABORT_EN && w_sys_edge) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_blink      <= '0;
            r_rst_core   <= 1'b1;
            r_rst_periph <= 1'b1;
            r_led_warn   <= 1'b0;
            r_busy       <= 1'b1;
          end else if (r_cnt == WARN_LAST) begin
            r_state    <= S_BOOT_FIRE;
            r_cnt      <= '0;
            r_blink    <= '0;
            r_programn <= PROG_ACT;
            r_led_warn <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_blink == BLINK_LAST) begin
              r_blink    <= '0;
              r_led_warn <= ~r_led_warn;
            end else begin
              r_blink <= r_blink + BLINK_W'(1);
            end
          end
        end

        // Terminal: PROGRAMN and LED stay asserted until rst.
        S_BOOT_FIRE: begin
          r_programn <= PROG_ACT;
          r_led_warn <= 1'b1;
        end

        // Unused encodings recover into a fresh reset sequence.
        default: begin
          r_state      <= S_HOLD;
          r_cnt        <= '0;
          r_blink      <= '0;
          r_rst_core   <= 1'b1;
          r_rst_periph <= 1'b1;
          r_programn   <= ~PROG_ACT;
          r_led_warn   <= 1'b0;
          r_busy       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rst_core      = r_rst_core;
  assign bus.rst_periph    = r_rst_periph;
  assign bus.boot_programn = r_programn;
  assign bus.led_warn      = r_led_warn;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: per-cycle expected outputs come from a time-based
// reference model (elapsed cycles since the last sequence/boot start) and are
// queued; a negedge monitor pops and compares against the DUT.
module tb_rst_sequencer;

  localparam int N      = 4096;
  localparam int T_HOLD = 8;
  localparam int T_GAP  = 4;
  localparam int T_WARN = 20;
  localparam int T_HALF = 5;

`ifdef RST_SEQ_BOOT_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef struct packed {
    logic core;
    logic periph;
    logic prog;
    logic led;
    logic busy;
  } exp_t;

  logic clk;
  logic rst;

  rst_sequencer_if u_if ();

  rst_sequencer #(
    .CLK_FREQUENCY        (1000),
    .REQ_LOGIC_LEVEL      (1),
    .RST_HOLD_CYCLES      (T_HOLD),
    .STAGE_GAP_CYCLES     (T_GAP),
    .BOOT_WARN_MS         (20),
    .BLINK_HZ             (100),
    .PROGRAMN_LOGIC_LEVEL (0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   sb_cyc[$];

  bit rst_h  [N];
  bit sys_h  [N];
  bit boot_h [N];
  int cyc;

  // Reference model state: mode (sequence or boot) and the cycle it started.
  bit m_warn;
  int m_start;

  int total;
  int bad;

  function automatic bit is_edge(input int c, input bit use_boot);
    bit cur;
    bit prv;
    if (c < 1) return 1'b0;
    cur = use_boot ? boot_h[c]   : sys_h[c];
    prv = use_boot ? boot_h[c-1] : sys_h[c-1];
    return cur && !prv && !rst_h[c];
  endfunction

  // Expected outputs for cycle n, given inputs recorded for cycles < n.
  task automatic push_expect(input int n);
    bit   sys_e;
    bit   boot_e;
    bit   fired;
    int   e;
    exp_t x;
    if (rst_h[n-1]) begin
      m_warn  = 1'b0;
      m_start = n;
    end else begin
      sys_e  = (n >= 2) ? is_edge(n-2, 1'b0) : 1'b0;
      boot_e = (n >= 2) ? is_edge(n-2, 1'b1) : 1'b0;
      fired  = m_warn && ((n - 1 - m_start) >= T_WARN);
      if (!fired) begin
        if (m_warn) begin
          if (ABORT && sys_e) begin
            m_warn  = 1'b0;
            m_start = n;
          end
        end else if (boot_e) begin
          m_warn  = 1'b1;
          m_start = n;
        end else if (sys_e) begin
          m_start = n;
        end
      end
    end
    e = n - m_start;
    if (!m_warn) begin
      x.core   = (e < T_HOLD);
      x.periph = (e < T_HOLD + T_GAP);
      x.busy   = (e < T_HOLD + T_GAP);
      x.led    = 1'b0;
      x.prog   = 1'b1;
    end else if (e < T_WARN) begin
      x.core   = 1'b1;
      x.periph = 1'b1;
      x.busy   = 1'b1;
      x.led    = ((e / T_HALF) % 2) == 0;
      x.prog   = 1'b1;
    end else begin
      x.core   = 1'b1;
      x.periph = 1'b1;
      x.busy   = 1'b1;
      x.led    = 1'b1;
      x.prog   = 1'b0;
    end
    sb_q.push_back(x);
    sb_cyc.push_back(n);
  endtask

  // One clock cycle: queue the expectation, apply the inputs for this cycle.
  task automatic step(input bit r, input bit s, input bit b);
    if (cyc < N) begin
      push_expect(cyc);
      rst              = r;
      u_if.sys_rst_req = s;
      u_if.boot_rst_req = b;
      rst_h[cyc]  = r;
      sys_h[cyc]  = s;
      boot_h[cyc] = b;
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    int   c;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      c = sb_cyc.pop_front();
      a = {u_if.rst_core, u_if.rst_periph, u_if.boot_programn, u_if.led_warn, u_if.busy};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs@cyc%0d: got core=%b periph=%b prog=%b led=%b busy=%b, want core=%b periph=%b prog=%b led=%b busy=%b",
                 c, a.core, a.periph, a.prog, a.led, a.busy,
                 e.core, e.periph, e.prog, e.led, e.busy);
      end
    end
  end

  initial begin
    bit s;
    bit b;
    total   = 0;
    bad     = 0;
    m_warn  = 1'b0;
    m_start = 0;
    rst               = 1'b1;
    u_if.sys_rst_req  = 1'b0;
    u_if.boot_rst_req = 1'b0;
    rst_h[0]  = 1'b1;
    sys_h[0]  = 1'b0;
    boot_h[0] = 1'b0;
    cyc = 1;
    @(posedge clk);
    #1;

    // Reset, then power-up sequence with no requests.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(20);

    // Single sys pulse from RUN.
    step(1'b0, 1'b1, 1'b0);
    idle(20);

    // Second sys pulse lands at HOLD count 5 and extends the hold.
    step(1'b0, 1'b1, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 1'b0);
    idle(20);

    // Boot pulse: warning blink, PROGRAMN fires, sys pulses ignored afterwards.
    step(1'b0, 1'b0, 1'b1);
    idle(25);
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b1);
    idle(6);
    step(1'b1, 1'b0, 1'b0);
    idle(15);

    // Simultaneous sys+boot: boot wins; sys pulse at warn cycle 10.
    step(1'b0, 1'b1, 1'b1);
    idle(9);
    step(1'b0, 1'b1, 1'b0);
    idle(30);
    step(1'b1, 1'b0, 1'b0);
    idle(15);

    // rst at warn cycle 15 while boot request stays high: no new boot edge.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    idle(5);

    // Random request levels with occasional rst.
    s = 1'b0;
    b = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0)  s = ~s;
      if ($urandom_range(29) == 0) b = ~b;
      step(($urandom_range(79) == 0), s, b);
    end
    idle(5);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
